// File: rtl/reg_dump_scanner.sv
// reg_dump_scanner
//
// Initiator side of the processor's register-observe port. On a start
// command it walks the index range lo_idx..hi_idx. For every index it drives
// `observe`, lets the core's `data_ob` settle, captures the returned word and
// offers it with its index on a valid/ready stream. It supports a
// single-sweep mode and a continuous mode that repeats until `stop`.
//
// Ports
//   clk        rising-edge system clock
//   reset      asynchronous, active-low reset
//   start      one-cycle request to begin a sweep (ignored while busy)
//   cont       sampled with start: 1 = repeat the sweep until stop
//   stop       ends the sweep after the word in flight is accepted
//   lo_idx     first index of the sweep, sampled with start
//   hi_idx     last index of the sweep, sampled with start
//   observe    register index driven to the core
//   data_ob    register value returned by the core
//   out_valid  out_data/out_idx hold a captured word
//   out_ready  consumer accepts the word when out_valid and out_ready are both 1
//   out_data   captured register value
//   out_idx    index of out_data
//   busy       a sweep is in progress
//   done       one-cycle pulse after a non-continuous sweep ends, or after
//              a start with an illegal range is rejected
module reg_dump_scanner #(
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = 5,
  parameter int SETTLE   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cont,
  input  logic             stop,
  input  logic [IDX_W-1:0] lo_idx,
  input  logic [IDX_W-1:0] hi_idx,
  output logic [IDX_W-1:0] observe,
  input  logic [31:0]      data_ob,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             busy,
  output logic             done
);

  localparam int DATA_W = 32;

  // The counter is loaded with SETTLE and the word is captured on the cycle
  // it reads zero. observe has therefore been stable for SETTLE full cycles
  // after the cycle in which it changed, so out_valid rises SETTLE+1 cycles
  // after the observe change.
  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE);
  localparam logic [IDX_W:0]   NREGS_W   = (IDX_W+1)'(NUM_REGS);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SEND   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    obs_q, obs_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]    lo_q, lo_d;
  logic [IDX_W-1:0]    hi_q, hi_d;
  logic                cont_q, cont_d;
  logic                stop_q, stop_d;
  logic                vld_q, vld_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                done_q, done_d;
  logic                busy_w;
  logic                stop_pend;

  function automatic logic range_bad(input logic [IDX_W-1:0] lo,
                                     input logic [IDX_W-1:0] hi);
    return (lo > hi) || ({1'b0, hi} >= NREGS_W);
  endfunction

  assign busy_w = (state_q != S_IDLE);
  // A stop arriving in the same cycle as the handshake still counts.
  assign stop_pend = stop_q | stop;

  always_comb begin
    state_d = state_q;
    obs_d   = obs_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    cont_d  = cont_q;
    stop_d  = stop_q | (stop & busy_w);
    vld_d   = vld_q;
    data_d  = data_q;
    idx_d   = idx_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        if (start) begin
          lo_d   = lo_idx;
          hi_d   = hi_idx;
          cont_d = cont;
          if (range_bad(lo_idx, hi_idx)) begin
            done_d = 1'b1;
          end else begin
            obs_d   = lo_idx;
            cnt_d   = SETTLE_LD;
            state_d = S_SETTLE;
          end
        end
      end

      S_SETTLE: begin
        if (cnt_q == 4'd0) begin
          data_d  = data_ob;
          idx_d   = obs_q;
          vld_d   = 1'b1;
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_SEND: begin
        if (vld_q && out_ready) begin
          vld_d = 1'b0;
          if (stop_pend) begin
            stop_d  = 1'b0;
            state_d = S_IDLE;
          end else if (obs_q != hi_q) begin
            obs_d   = obs_q + IDX_ONE;
            cnt_d   = SETTLE_LD;
            state_d = S_SETTLE;
          end else if (cont_q) begin
            obs_d   = lo_q;
            cnt_d   = SETTLE_LD;
            state_d = S_SETTLE;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      obs_q   <= '0;
      cnt_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      cont_q  <= 1'b0;
      stop_q  <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      obs_q   <= obs_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cont_q  <= cont_d;
      stop_q  <= stop_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign observe   = obs_q;
  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign busy      = busy_w;
  assign done      = done_q;

endmodule
